// File: rtl/block_shape.sv
`default_nettype none
// ============================================================================
// Module      : block_shape
// Description : Drawing engine for one scrolling obstacle block. Answers the
//               sequencer's draw_start/draw_done handshake, streams one pixel
//               per clock (x, y, colour, plot) while drawing, and scrolls the
//               block left on every update_screen pulse. Moves that arrive
//               mid-draw are deferred to the draw-exit edge so a block is
//               never torn.
// Revision    : 1.0 - initial release
// ============================================================================
module block_shape #(
  parameter logic [10:0] START_X = 11'd159,
  parameter logic [10:0] START_Y = 11'd100,
  parameter int          WIDTH   = 8,
  parameter int          HEIGHT  = 8,
  parameter int          STEP    = 1,
  parameter logic [2:0]  COLOUR  = 3'b111
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load_reset,
  input  logic        draw_start,
  input  logic        update_screen,
  output logic [10:0] send_x,
  output logic [10:0] send_y,
  output logic [2:0]  send_colour,
  output logic        plot,
  output logic        draw_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0]  c_last_x = 5'(WIDTH - 1);
  localparam logic [4:0]  c_last_y = 5'(HEIGHT - 1);
  localparam logic [10:0] c_step   = 11'(STEP);
  localparam logic [10:0] c_max_x  = 11'd159;

  state_t      r_state;
  logic [10:0] r_pos_x;
  logic [4:0]  r_cx;
  logic [4:0]  r_cy;
  logic        r_pending;
  logic [10:0] r_send_x;
  logic [10:0] r_send_y;
  logic [2:0]  r_send_colour;
  logic        r_plot;
  logic        r_draw_done;

  logic [10:0] w_pix_x;
  logic [10:0] w_pix_y;
  logic [10:0] w_stepped_x;
  logic        w_last_pix;

  // Current scan pixel, next scrolled position (wrapping instead of going negative)
  assign w_pix_x     = r_pos_x + {6'd0, r_cx};
  assign w_pix_y     = START_Y + {6'd0, r_cy};
  assign w_stepped_x = (r_pos_x < c_step) ? START_X : (r_pos_x - c_step);
  assign w_last_pix  = (r_cx == c_last_x) && (r_cy == c_last_y);

  assign send_x      = r_send_x;
  assign send_y      = r_send_y;
  assign send_colour = r_send_colour;
  assign plot        = r_plot;
  assign draw_done   = r_draw_done;

  // Handshake FSM, raster scan, position scrolling and registered pixel bus
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_pos_x       <= START_X;
      r_cx          <= 5'd0;
      r_cy          <= 5'd0;
      r_pending     <= 1'b0;
      r_send_x      <= 11'd0;
      r_send_y      <= 11'd0;
      r_send_colour <= 3'd0;
      r_plot        <= 1'b0;
      r_draw_done   <= 1'b0;
    end else if (load_reset) begin
      r_state     <= IDLE;
      r_pos_x     <= START_X;
      r_pending   <= 1'b0;
      r_plot      <= 1'b0;
      r_draw_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_plot      <= 1'b0;
          r_draw_done <= 1'b0;
          if (update_screen) r_pos_x <= w_stepped_x;
          if (draw_start) begin
            r_state <= DRAW;
            r_cx    <= 5'd0;
            r_cy    <= 5'd0;
          end
        end
        DRAW: begin
          if (!draw_start) begin
            // Abort: leave DRAW, applying any deferred move on this exit edge
            r_state     <= IDLE;
            r_plot      <= 1'b0;
            r_draw_done <= 1'b0;
            r_pending   <= 1'b0;
            if (r_pending || update_screen) r_pos_x <= w_stepped_x;
          end else begin
            r_send_x      <= w_pix_x;
            r_send_y      <= w_pix_y;
            r_send_colour <= COLOUR;
            r_plot        <= (w_pix_x <= c_max_x);
            if (w_last_pix) begin
              r_state   <= DONE;
              r_pending <= 1'b0;
              if (r_pending || update_screen) r_pos_x <= w_stepped_x;
            end else begin
              if (update_screen) r_pending <= 1'b1;
              if (r_cx == c_last_x) begin
                r_cx <= 5'd0;
                r_cy <= r_cy + 5'd1;
              end else begin
                r_cx <= r_cx + 5'd1;
              end
            end
          end
        end
        DONE: begin
          r_plot      <= 1'b0;
          r_draw_done <= draw_start;
          if (update_screen) r_pos_x <= w_stepped_x;
          if (!draw_start) r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_plot      <= 1'b0;
          r_draw_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_shape.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_shape
// Description : Scoreboard bench for block_shape. Stimulus pushes expected
//               plotted pixels into a queue; a monitor pops and compares on
//               every plot cycle. A second instance with STEP=4 covers the
//               wide-step wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_shape;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        load_reset = 1'b0;
  logic        draw_start = 1'b0;
  logic        update_screen = 1'b0;
  logic [10:0] send_x;
  logic [10:0] send_y;
  logic [2:0]  send_colour;
  logic        plot;
  logic        draw_done;

  logic        upd4 = 1'b0;
  logic [10:0] sx4;
  logic [10:0] sy4;
  logic [2:0]  sc4;
  logic        plot4;
  logic        done4;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_p;

  always #5 clock = ~clock;

  block_shape u_dut (
    .clock(clock), .resetn(resetn), .load_reset(load_reset),
    .draw_start(draw_start), .update_screen(update_screen),
    .send_x(send_x), .send_y(send_y), .send_colour(send_colour),
    .plot(plot), .draw_done(draw_done)
  );

  block_shape #(.STEP(4)) u_dut4 (
    .clock(clock), .resetn(resetn), .load_reset(1'b0),
    .draw_start(1'b0), .update_screen(upd4),
    .send_x(sx4), .send_y(sy4), .send_colour(sc4),
    .plot(plot4), .draw_done(done4)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every plotted pixel must match the head of the expected queue
  always @(negedge clock) begin
    if (resetn && plot) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot actual=(%0d,%0d) required=none", send_x, send_y);
      end else begin
        mon_p = exp_q.pop_front();
        if (send_x !== mon_p.x || send_y !== mon_p.y || send_colour !== 3'd7) begin
          errors++;
          $display("FAIL pixel actual=(%0d,%0d,c%0d) required=(%0d,%0d,c7)",
                   send_x, send_y, send_colour, mon_p.x, mon_p.y);
        end
      end
    end
  end

  task automatic push_pixels(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      if (base + (i % 8) <= 159)
        exp_q.push_back('{x: 11'(base + (i % 8)), y: 11'(100 + (i / 8))});
    end
  endtask

  task automatic pulses(input int n, input bit on4);
    for (int i = 0; i < n; i++) begin
      if (on4) upd4 = 1'b1; else update_screen = 1'b1;
      tick();
      upd4 = 1'b0;
      update_screen = 1'b0;
      tick();
    end
  endtask

  // Full 8x8 draw; update pulses are raised after tick number upd_a / upd_b.
  // draw_start rises just after edge k-1, so edge k is tick 1, the first pixel
  // follows tick 2 and draw_done follows edge k+65, i.e. tick 66.
  task automatic do_draw(input int base, input int upd_a, input int upd_b);
    int n;
    int held;
    bit got;
    push_pixels(base, 64);
    draw_start = 1'b1;
    n = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      tick();
      n++;
      update_screen = (n == upd_a) || (n == upd_b);
      if (n == 2) begin
        chk("first_pixel_x", int'(send_x), base);
        chk("first_pixel_y", int'(send_y), 100);
      end
      if (draw_done) got = 1'b1;
    end
    update_screen = 1'b0;
    chk("done_latency", n, 66);
    held = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (draw_done) held++;
    end
    chk("done_held", held, 3);
    draw_start = 1'b0;
    tick();
    chk("done_fall", int'(draw_done), 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int seen;
    // Reset state
    #2;
    chk("rst_plot", int'(plot), 0);
    chk("rst_done", int'(draw_done), 0);
    chk("rst_send_x", int'(send_x), 0);
    chk("rst_send_y", int'(send_y), 0);
    chk("rst_colour", int'(send_colour), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("rst_pos", int'(u_dut.r_pos_x), 159);

    // Default draw at x=159: only column 0 visible, the rest clipped
    do_draw(159, 0, 0);

    // Scroll to 0, draw fully visible, then wrap
    pulses(159, 1'b0);
    chk("scroll_zero", int'(u_dut.r_pos_x), 0);
    do_draw(0, 0, 0);
    pulses(1, 1'b0);
    chk("wrap_step1", int'(u_dut.r_pos_x), 159);

    // STEP=4: 39 pulses bring 159 down to 3, the next one wraps
    pulses(39, 1'b1);
    chk("step4_at3", int'(u_dut4.r_pos_x), 3);
    pulses(1, 1'b1);
    chk("wrap_step4", int'(u_dut4.r_pos_x), 159);

    // Deferred updates: pixels keep the base, one move on exit
    pulses(59, 1'b0);
    chk("pos_100", int'(u_dut.r_pos_x), 100);
    do_draw(100, 10, 0);
    chk("deferred_one", int'(u_dut.r_pos_x), 99);
    do_draw(99, 10, 20);
    chk("deferred_two", int'(u_dut.r_pos_x), 98);

    // Abort after 20 pixels (pixel i follows tick i+2)
    push_pixels(98, 20);
    draw_start = 1'b1;
    repeat (21) tick();
    draw_start = 1'b0;
    tick();
    chk("abort_plot", int'(plot), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (draw_done || plot) seen++;
    end
    chk("abort_quiet", seen, 0);
    chk("abort_queue", exp_q.size(), 0);
    do_draw(98, 0, 0);

    // load_reset beats update_screen and draw_start
    pulses(48, 1'b0);
    chk("pos_50", int'(u_dut.r_pos_x), 50);
    load_reset = 1'b1;
    update_screen = 1'b1;
    draw_start = 1'b1;
    tick();
    update_screen = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (plot || draw_done) seen++;
    end
    chk("prio_no_draw", seen, 0);
    chk("prio_pos", int'(u_dut.r_pos_x), 159);
    load_reset = 1'b0;
    draw_start = 1'b0;
    tick();
    do_draw(159, 0, 0);

    // Asynchronous reset while pixels are being plotted
    pulses(59, 1'b0);
    push_pixels(100, 5);
    draw_start = 1'b1;
    repeat (6) tick();
    @(negedge clock);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_plot", int'(plot), 0);
    chk("arst_done", int'(draw_done), 0);
    chk("arst_send_x", int'(send_x), 0);
    chk("arst_send_y", int'(send_y), 0);
    chk("arst_colour", int'(send_colour), 0);
    chk("arst_pos", int'(u_dut.r_pos_x), 159);
    draw_start = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    chk("arst_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
